// File: rtl/v_tile_pkg.sv
// Shared types and config-word field positions for the vector ALU tile.
package v_tile_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_MIN = 3'd3,
    OP_MAX = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CFG_DEST_LSB = 0;
  localparam int CFG_DEST_W   = 4;
  localparam int CFG_OP_LSB   = 4;
  localparam int CFG_OP_W     = 3;
  localparam int CFG_SAT_BIT  = 7;
  localparam int CFG_ACC_BIT  = 8;
  localparam int CFG_KEEP_BIT = 9;

endpackage

// File: rtl/v_alu_tile_if.sv
// Bus bundle of the vector ALU tile: three rdy/en/ack write channels, start pulse and result handshake.
interface v_alu_tile_if #(
  parameter int width      = 16,
  parameter int num_inputs = 4,
  parameter int num_regs   = 16
);
  import v_tile_pkg::*;

  // Write channels: a word is captured on a cycle where write_en && write_rdy; write_ack
  // pulses the cycle after. Result: out_valid holds result/dest stable until out_ready.
  logic                          on_off;
  logic                          write_en1, write_en2, write_en3;
  logic                          write_rdy1, write_rdy2, write_rdy3;
  logic                          write_ack1, write_ack2, write_ack3;
  logic [width*num_inputs-1:0]   w_data_in1, w_data_in2;
  logic [width-1:0]              w_data_in3;
  logic [width*num_inputs-1:0]   result_out;
  logic [$clog2(num_regs)-1:0]   dest_info;
  logic                          out_valid;
  logic                          out_ready;
  state_e                        dbg_state;

  modport slave (
    input  on_off, write_en1, write_en2, write_en3,
    input  w_data_in1, w_data_in2, w_data_in3, out_ready,
    output write_rdy1, write_rdy2, write_rdy3,
    output write_ack1, write_ack2, write_ack3,
    output result_out, dest_info, out_valid, dbg_state
  );

  modport master (
    output on_off, write_en1, write_en2, write_en3,
    output w_data_in1, w_data_in2, w_data_in3, out_ready,
    input  write_rdy1, write_rdy2, write_rdy3,
    input  write_ack1, write_ack2, write_ack3,
    input  result_out, dest_info, out_valid, dbg_state
  );
endinterface

// File: rtl/v_lane_alu.sv
// Single-lane signed ALU with optional saturation of ADD/SUB/MUL.
module v_lane_alu
  import v_tile_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  op_e              op,
  input  logic             sat,
  output logic [width-1:0] y
);

  localparam logic [width-1:0] SMAX = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] SMIN = {1'b1, {(width-1){1'b0}}};

  logic [width:0]     sum;
  logic [width:0]     dif;
  logic [2*width-1:0] prod;
  logic               sum_ovf;
  logic               dif_ovf;
  logic               mul_ovf;

  always_comb begin
    sum  = {a[width-1], a} + {b[width-1], b};
    dif  = {a[width-1], a} - {b[width-1], b};
    prod = $signed({{width{a[width-1]}}, a}) * $signed({{width{b[width-1]}}, b});
    // Overflow: the extra high bits disagree with the sign bit of the narrow result.
    sum_ovf = sum[width] != sum[width-1];
    dif_ovf = dif[width] != dif[width-1];
    mul_ovf = ~(&prod[2*width-1:width-1]) && (|prod[2*width-1:width-1]);

    y = '0;
    case (op)
      OP_ADD: y = (sat && sum_ovf) ? (sum[width] ? SMIN : SMAX) : sum[width-1:0];
      OP_SUB: y = (sat && dif_ovf) ? (dif[width] ? SMIN : SMAX) : dif[width-1:0];
      OP_MUL: y = (sat && mul_ovf) ? (prod[2*width-1] ? SMIN : SMAX) : prod[width-1:0];
      OP_MIN: y = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX: y = ($signed(a) > $signed(b)) ? a : b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/v_alu_tile.sv
// Vector ALU tile: operand/config slots with write handshakes, IDLE/EXEC/DONE FSM, lane-parallel ALUs.
module v_alu_tile
  import v_tile_pkg::*;
#(
  parameter int width      = 16,
  parameter int num_inputs = 4,
  parameter int num_regs   = 16
) (
  input logic         clk,
  input logic         reset,
  v_alu_tile_if.slave bus
);

  localparam int VW = width * num_inputs;
  localparam int DW = $clog2(num_regs);

  state_e           state, state_nxt;
  logic [VW-1:0]    a_q, b_q, res_q;
  logic [width-1:0] cfg_q;
  logic [DW-1:0]    dest_q;
  logic             full1, full2, full3;
  logic             ack1, ack2, ack3;
  logic             cap1, cap2, cap3;
  logic             release_slots;
  logic [VW-1:0]    lane_y;
  op_e              cfg_op;
  logic             unused_cfg;

  assign cfg_op     = op_e'(cfg_q[CFG_OP_LSB +: CFG_OP_W]);
  assign unused_cfg = ^cfg_q[width-1:CFG_KEEP_BIT];

  for (genvar i = 0; i < num_inputs; i++) begin : g_lane
    v_lane_alu #(.width(width)) u_alu (
      .a   (a_q[i*width +: width]),
      .b   (b_q[i*width +: width]),
      .op  (cfg_op),
      .sat (cfg_q[CFG_SAT_BIT]),
      .y   (lane_y[i*width +: width])
    );
  end

  assign cap1 = bus.write_en1 && !full1;
  assign cap2 = bus.write_en2 && !full2;
  assign cap3 = bus.write_en3 && !full3;
  assign release_slots = (state == ST_DONE) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Start uses registered full flags, so a start in the capture cycle of the last operand is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.on_off && full1 && full2 && full3) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      cfg_q  <= '0;
      res_q  <= '0;
      dest_q <= '0;
      full1  <= 1'b0;
      full2  <= 1'b0;
      full3  <= 1'b0;
      ack1   <= 1'b0;
      ack2   <= 1'b0;
      ack3   <= 1'b0;
    end else begin
      ack1 <= cap1;
      ack2 <= cap2;
      ack3 <= cap3;

      // Captures and releases never coincide: every slot is full while in DONE.
      if (cap1) begin
        a_q   <= bus.w_data_in1;
        full1 <= 1'b1;
      end else if (release_slots) begin
        if (cfg_q[CFG_ACC_BIT]) a_q <= res_q;
        else                    full1 <= 1'b0;
      end

      if (cap2) begin
        b_q   <= bus.w_data_in2;
        full2 <= 1'b1;
      end else if (release_slots) begin
        full2 <= 1'b0;
      end

      if (cap3) begin
        cfg_q <= bus.w_data_in3;
        full3 <= 1'b1;
      end else if (release_slots && !cfg_q[CFG_KEEP_BIT]) begin
        full3 <= 1'b0;
      end

      if (state == ST_EXEC) begin
        res_q  <= lane_y;
        dest_q <= cfg_q[CFG_DEST_LSB +: DW];
      end
    end
  end

  assign bus.write_rdy1 = !full1;
  assign bus.write_rdy2 = !full2;
  assign bus.write_rdy3 = !full3;
  assign bus.write_ack1 = ack1;
  assign bus.write_ack2 = ack2;
  assign bus.write_ack3 = ack3;
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.result_out = res_q;
  assign bus.dest_info  = dest_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_v_alu_tile.sv
// Directed bench for v_alu_tile: arithmetic reference model, expected-result queue and per-cycle output compare.
module tb_v_alu_tile;
  import v_tile_pkg::*;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int R  = 16;
  localparam int VW = W * L;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  v_alu_tile_if #(.width(W), .num_inputs(L), .num_regs(R)) vif ();
  v_alu_tile #(.width(W), .num_inputs(L), .num_regs(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lane_model(input logic [15:0] cfg, input logic [15:0] a,
                                             input logic [15:0] b);
    int     op;
    bit     sat;
    longint sa, sb, r;
    op  = int'(cfg[6:4]);
    sat = cfg[7];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      0: r = sa + sb;
      1: r = sa - sb;
      2: r = sa * sb;
      3: r = (sa < sb) ? sa : sb;
      4: r = (sa > sb) ? sa : sb;
      5: r = longint'(a & b);
      6: r = longint'(a | b);
      default: r = longint'(a ^ b);
    endcase
    if (sat && op <= 2) begin
      if (r > 32767)       r = 32767;
      else if (r < -32768) r = -32768;
    end
    return r[15:0];
  endfunction

  function automatic logic [VW-1:0] vec_model(input logic [15:0] cfg, input logic [VW-1:0] a,
                                             input logic [VW-1:0] b);
    logic [VW-1:0] y;
    for (int i = 0; i < L; i++) y[i*W +: W] = lane_model(cfg, a[i*W +: W], b[i*W +: W]);
    return y;
  endfunction

  function automatic logic [VW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {e3[15:0], e2[15:0], e1[15:0], e0[15:0]};
  endfunction

  bit            m_full [3];
  bit            m_busy;
  logic [VW-1:0] m_a, m_b, m_res;
  logic [15:0]   m_cfg;

  logic [VW-1:0] exp_q[$];
  logic [3:0]    exp_dest_q[$];
  int            exp_cyc_q[$];

  // ---------------- driver tasks ----------------
  function automatic logic get_ack(input int ch);
    case (ch)
      1: return vif.write_ack1;
      2: return vif.write_ack2;
      default: return vif.write_ack3;
    endcase
  endfunction

  function automatic logic get_rdy(input int ch);
    case (ch)
      1: return vif.write_rdy1;
      2: return vif.write_rdy2;
      default: return vif.write_rdy3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
    m_busy = 1'b0;
    exp_q.delete();
    exp_dest_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_vals();
    chk("rst write_rdy1", vif.write_rdy1, 1);
    chk("rst write_rdy2", vif.write_rdy2, 1);
    chk("rst write_rdy3", vif.write_rdy3, 1);
    chk("rst write_acks", {vif.write_ack1, vif.write_ack2, vif.write_ack3}, 0);
    chk("rst out_valid", vif.out_valid, 0);
    chk("rst result_out", vif.result_out, 0);
    chk("rst dest_info", vif.dest_info, 0);
    chk("rst state", vif.dbg_state, ST_IDLE);
  endtask

  task automatic do_write(input int ch, input logic [VW-1:0] data);
    bit take;
    take = !m_full[ch-1];
    case (ch)
      1: begin vif.write_en1 = 1'b1; vif.w_data_in1 = data; end
      2: begin vif.write_en2 = 1'b1; vif.w_data_in2 = data; end
      default: begin vif.write_en3 = 1'b1; vif.w_data_in3 = data[15:0]; end
    endcase
    @(posedge clk);
    #1;
    vif.write_en1 = 1'b0;
    vif.write_en2 = 1'b0;
    vif.write_en3 = 1'b0;
    if (take) begin
      m_full[ch-1] = 1'b1;
      case (ch)
        1: m_a = data;
        2: m_b = data;
        default: m_cfg = data[15:0];
      endcase
    end
    chk($sformatf("write_ack%0d", ch), get_ack(ch), take);
    chk($sformatf("write_rdy%0d after write", ch), get_rdy(ch), 0);
    @(posedge clk);
    #1;
    chk($sformatf("write_ack%0d one cycle", ch), get_ack(ch), 0);
  endtask

  task automatic start();
    bit go;
    go = !m_busy && m_full[0] && m_full[1] && m_full[2];
    vif.on_off = 1'b1;
    if (go) begin
      m_res = vec_model(m_cfg, m_a, m_b);
      exp_q.push_back(m_res);
      exp_dest_q.push_back(m_cfg[3:0]);
      exp_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    vif.on_off = 1'b0;
    if (go) m_busy = 1'b1;
  endtask

  task automatic wait_valid(output logic [VW-1:0] res);
    int i;
    for (i = 0; i < 20; i++) begin
      if (vif.out_valid) break;
      @(posedge clk);
      #1;
    end
    if (i == 20) chk("out_valid timeout", 0, 1);
    res = vif.result_out;
  endtask

  task automatic accept();
    vif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    vif.out_ready = 1'b0;
    if (m_busy) begin
      m_busy    = 1'b0;
      m_full[1] = 1'b0;
      if (m_cfg[8]) m_a = m_res;
      else          m_full[0] = 1'b0;
      if (!m_cfg[9]) m_full[2] = 1'b0;
    end
    chk("out_valid after accept", vif.out_valid, 0);
    chk("write_rdy1 after accept", vif.write_rdy1, !m_full[0]);
    chk("write_rdy2 after accept", vif.write_rdy2, !m_full[1]);
    chk("write_rdy3 after accept", vif.write_rdy3, !m_full[2]);
  endtask

  task automatic run_op(input logic [15:0] cfg, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        output logic [VW-1:0] res);
    do_write(3, {48'd0, cfg});
    do_write(1, a);
    do_write(2, b);
    start();
    wait_valid(res);
    accept();
  endtask

  // ---------------- scoreboard compare ----------------
  logic          prev_valid = 1'b0;
  logic [VW-1:0] hold_res;
  logic [3:0]    hold_dest;
  logic [VW-1:0] sb_res;
  logic [3:0]    sb_dest;
  int            sb_cyc;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (vif.out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected out_valid", 1, 0);
        end else begin
          sb_res  = exp_q.pop_front();
          sb_dest = exp_dest_q.pop_front();
          sb_cyc  = exp_cyc_q.pop_front();
          chk("result_out", vif.result_out, sb_res);
          chk("dest_info", vif.dest_info, sb_dest);
          chk("latency", cyc - sb_cyc, 2);
        end
      end else if (vif.out_valid && prev_valid) begin
        chk("result_out stable", vif.result_out, hold_res);
        chk("dest_info stable", vif.dest_info, hold_dest);
      end
      prev_valid <= vif.out_valid;
      hold_res   <= vif.result_out;
      hold_dest  <= vif.dest_info;
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [15:0] cfg;
    logic [15:0] exp;
  } op_vec_t;

  op_vec_t       op_tab[6];
  logic [VW-1:0] res;

  initial begin
    vif.on_off     = 1'b0;
    vif.write_en1  = 1'b0;
    vif.write_en2  = 1'b0;
    vif.write_en3  = 1'b0;
    vif.w_data_in1 = '0;
    vif.w_data_in2 = '0;
    vif.w_data_in3 = '0;
    vif.out_ready  = 1'b0;
    m_a = '0; m_b = '0; m_res = '0; m_cfg = '0;
    do_reset();
    check_reset_vals();

    // Basic ADD with dest 1
    run_op(16'h0001, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), res);
    chk("t1 add literal", res, 64'h000C_000A_0008_0006);

    // Saturation
    run_op(16'h0090, {4{16'h8000}}, {4{16'h0001}}, res);
    chk("t2 sub sat", res, {4{16'h8000}});
    run_op(16'h0010, {4{16'h8000}}, {4{16'h0001}}, res);
    chk("t2 sub wrap", res, {4{16'h7FFF}});
    run_op(16'h0080, {4{16'h7FFF}}, {4{16'h0001}}, res);
    chk("t2 add sat", res, {4{16'h7FFF}});
    run_op(16'h0000, {4{16'h7FFF}}, {4{16'h0001}}, res);
    chk("t2 add wrap", res, {4{16'h8000}});

    // Remaining ops on A=FFFE, B=0003
    op_tab[0] = '{16'h0020, 16'hFFFA};
    op_tab[1] = '{16'h0030, 16'hFFFE};
    op_tab[2] = '{16'h0040, 16'h0003};
    op_tab[3] = '{16'h0050, 16'h0002};
    op_tab[4] = '{16'h0060, 16'hFFFF};
    op_tab[5] = '{16'h0070, 16'hFFFD};
    foreach (op_tab[i]) begin
      run_op(op_tab[i].cfg, {4{16'hFFFE}}, {4{16'h0003}}, res);
      chk($sformatf("t3 op cfg %h", op_tab[i].cfg), res, {4{op_tab[i].exp}});
    end

    // Accumulate with sticky config
    run_op(16'h0300, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), res);
    chk("t4 acc first", res, {4{16'h0003}});
    chk("t4 rdy1 held", vif.write_rdy1, 0);
    chk("t4 rdy3 held", vif.write_rdy3, 0);
    do_write(2, pack4(3, 3, 3, 3));
    start();
    wait_valid(res);
    chk("t4 acc second", res, {4{16'h0006}});
    chk("t4 rdy1 in done", vif.write_rdy1, 0);
    chk("t4 rdy3 in done", vif.write_rdy3, 0);
    accept();
    do_reset();
    check_reset_vals();

    // Back-pressure in DONE
    do_write(3, 64'h0005);
    do_write(1, pack4(100, 200, 300, 400));
    do_write(2, pack4(1, 2, 3, 4));
    start();
    wait_valid(res);
    chk("t5 result", res, pack4(101, 202, 303, 404));
    for (int i = 0; i < 10; i++) begin
      if (i == 4) start();
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("t5 out_valid held", vif.out_valid, 1);
    chk("t5 rdy1 held", vif.write_rdy1, 0);
    chk("t5 rdy2 held", vif.write_rdy2, 0);
    chk("t5 dest held", vif.dest_info, 5);
    accept();

    // Start with B empty, start in same cycle as last capture, retry while full, reset in DONE
    do_write(3, 64'h0002);
    do_write(1, pack4(10, 20, 30, 40));
    start();
    chk("t6 idle without B", vif.dbg_state, ST_IDLE);
    chk("t6 no valid without B", vif.out_valid, 0);
    vif.write_en2  = 1'b1;
    vif.w_data_in2 = pack4(1, 1, 1, 1);
    vif.on_off     = 1'b1;
    @(posedge clk);
    #1;
    vif.write_en2 = 1'b0;
    vif.on_off    = 1'b0;
    m_full[1] = 1'b1;
    m_b       = pack4(1, 1, 1, 1);
    chk("t6 ack2 same-cycle", vif.write_ack2, 1);
    chk("t6 start ignored", vif.dbg_state, ST_IDLE);
    do_write(1, pack4(9, 9, 9, 9));
    start();
    wait_valid(res);
    chk("t6 result", res, pack4(11, 21, 31, 41));
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_reset_vals();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals();

    chk("expected queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1);
  end

endmodule
